regfile_mp_sb: RTL
==================

Name: regfile_mp_sb

Overview:
Parametrised successor to the stage-2 register file in the MIPS-32 pipeline. It provides NUM_RD registered read ports, NUM_WR write ports, a hardwired-zero r0 and write-first bypass. A per-register pending scoreboard lets decode detect RAW hazards against in-flight producers. It sits in the ID stage, is written by WB (and late-load) ports, and is read by the decode/issue logic.

Parameters:
DW, 32, data width in bits
DEPTH, 32, number of architectural registers (power of 2)
AW, $clog2(DEPTH), register address width
NUM_RD, 2, number of read ports (rs, rt by default)
NUM_WR, 2, number of write ports (port 0 = WB, port 1 = late load)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*AW  packed read addresses, port i at [i*AW +: AW]
rd_data  out  NUM_RD*DW  packed registered read data
rd_busy  out  NUM_RD  registered pending flag for the register read on each port
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*AW  packed write addresses
wr_data  in  NUM_WR*DW  packed write data
sb_set_en  in  1  mark sb_set_addr as pending (producer issued)
sb_set_addr  in  AW  register to mark pending
sb_flush  in  1  synchronous clear of all pending bits (pipeline flush)

Behaviour:
- Reset (rst_n low, async): all registers = 0; rd_data = 0; rd_busy = 0; all pending bits = 0. Reset asserted mid-operation wins over any write, set or read in that cycle.
- Register 0: writes are ignored and reads always return 0. Its pending bit is never set, so rd_busy for addr 0 is always 0.
- Write: at the rising edge, wr_en[j] with wr_addr[j] != 0 updates the register.
  - Two ports write the same address in the same cycle: the highest-index port wins.
  - Different addresses: both writes commit.
- Read: 1-cycle latency. With rd_en[i] = 1 at edge N, rd_data[i] after edge N holds the post-edge-N register value.
  - Write-first bypass: a same-cycle write to the same address returns the new data, using the winning writer's value.
  - rd_en[i] = 0: rd_data[i] and rd_busy[i] hold their previous values.
  - All read ports are independent; any ports may read the same address.
- Scoreboard, evaluated at each edge in priority order:
  1. sb_flush: all pending bits cleared. A same-cycle sb_set_en is ignored.
  2. Otherwise, any wr_en[j] to address A clears pending[A].
  3. Then sb_set_en sets pending[sb_set_addr]. When set and clear hit the same address in one cycle, set wins (a new producer was issued).
  4. sb_set_addr = 0 is ignored.
- rd_busy[i]: captured with rd_data[i] when rd_en[i] = 1. It equals the post-edge pending state of rd_addr[i], so a same-cycle clear shows 0 and a same-cycle set shows 1.
- Widths: all address compares use the full AW bits. No out-of-range addresses exist because DEPTH = 2^AW.
- No combinational path from inputs to outputs; all outputs are flops.

Decomposition:
- Package regfile_pkg holds:
  - default constants: DW = 32, DEPTH = 32, NUM_RD = 2, NUM_WR = 2
  - ZERO_REG = 0
  - named port indices: RD_RS = 0, RD_RT = 1, WR_WB = 0, WR_LD = 1
- One sub-module, regfile_scoreboard: the DEPTH-bit pending vector with set/clear/flush priority and a per-port post-edge lookup.
- The register array, write arbitration and bypass stay in the top module.

Test Plan:
1. Reset, then read rs = 7, rt = 10 with rd_en = 11 -> rd_data = 0/0 and rd_busy = 00 one cycle later.
2. wr_en = 01, wr_addr0 = 11, wr_data0 = 3, with rd_en = 01 and rd_addr0 = 11 in the same cycle -> rd_data[0] = 3 next cycle (bypass). Next cycle with rd_en = 00 and wr_data0 = 9 to addr 11 -> rd_data[0] stays 3; a later read returns 9.
3. Both ports write addr 5 (port 0 = 0xAAAA, port 1 = 0x5555) -> reading 5 returns 0x5555. Write 0xFFFF to addr 0 -> reading 0 returns 0.
4. sb_set_en with addr 8 -> reading 8 gives rd_busy = 1. WB write to 8 -> next read gives rd_busy = 0. Same-cycle set and write to 8 -> rd_busy = 1.
5. Set pending on 3, 4 and 6, then sb_flush together with sb_set_en on addr 9 -> reading 3/4/6/9 gives rd_busy = 0 on all.
6. Write 0x1234 to addr 2, deassert rst_n mid-cycle while a write is pending -> rd_data = 0 immediately; a read of 2 after reset returns 0 with rd_busy = 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants for the multi-port scoreboarded register file
// Purpose: default geometry, the hardwired-zero register index and named port indices.
package regfile_pkg;

    localparam int DW_DEFAULT     = 32;
    localparam int DEPTH_DEFAULT  = 32;
    localparam int NUM_RD_DEFAULT = 2;
    localparam int NUM_WR_DEFAULT = 2;

    localparam int ZERO_REG = 0;

    // Read ports: rs / rt. Write ports: writeback / late load.
    localparam int RD_RS = 0;
    localparam int RD_RT = 1;
    localparam int WR_WB = 0;
    localparam int WR_LD = 1;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits with flush/clear/set priority
// Purpose: tracks registers with an in-flight producer and exposes the post-edge
//          pending state of each read address so it can be captured with read data.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   wr_en, wr_addr          write ports; any write clears the target's pending bit
//   sb_set_en, sb_set_addr  mark a register pending (register 0 ignored)
//   sb_flush                clear every pending bit, overriding a same-cycle set
//   rd_addr                 packed read addresses to look up
//   rd_pend                 pending state each read address will have after this edge
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int AW     = $clog2(DEPTH),
    parameter int NUM_RD = NUM_RD_DEFAULT,
    parameter int NUM_WR = NUM_WR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 sb_set_en,
    input  logic [AW-1:0]        sb_set_addr,
    input  logic                 sb_flush,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_pend
);

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;

    // Set is applied after the clears so a newly issued producer survives a
    // retiring write to the same register.
    always_comb begin
        pending_nxt = pending;
        if (sb_flush) begin
            pending_nxt = '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j]) begin
                    pending_nxt[wr_addr[j*AW +: AW]] = 1'b0;
                end
            end
            if (sb_set_en && (sb_set_addr != AW'(ZERO_REG))) begin
                pending_nxt[sb_set_addr] = 1'b1;
            end
        end
        pending_nxt[ZERO_REG] = 1'b0;
    end

    always_comb begin
        rd_pend = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_pend[i] = pending_nxt[rd_addr[i*AW +: AW]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with write-first bypass and pending scoreboard
// Purpose: ID-stage register file; r0 reads as zero, writes land at the rising edge,
//          reads are registered and return the post-edge value of the addressed register.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   rd_en, rd_addr                 per-port read enable and packed addresses
//   rd_data, rd_busy               registered read data and pending flag (held when rd_en=0)
//   wr_en, wr_addr, wr_data        packed write ports; highest index wins on collision
//   sb_set_en, sb_set_addr         mark a register as having an in-flight producer
//   sb_flush                       clear all pending bits
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DW     = DW_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int AW     = $clog2(DEPTH),
    parameter int NUM_RD = NUM_RD_DEFAULT,
    parameter int NUM_WR = NUM_WR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RD-1:0]    rd_en,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic [NUM_WR*DW-1:0] wr_data,
    input  logic                 sb_set_en,
    input  logic [AW-1:0]        sb_set_addr,
    input  logic                 sb_flush
);

    logic [DW-1:0]     regs [DEPTH];
    logic [DW-1:0]     byp  [NUM_RD];
    logic [NUM_RD-1:0] rd_pend;

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .sb_flush    (sb_flush),
        .rd_addr     (rd_addr),
        .rd_pend     (rd_pend)
    );

    // Post-edge value per read port: ascending scan so the highest-index
    // matching writer overrides, mirroring the write arbitration below.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            byp[i] = regs[rd_addr[i*AW +: AW]];
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
                    byp[i] = wr_data[j*DW +: DW];
                end
            end
            if (rd_addr[i*AW +: AW] == AW'(ZERO_REG)) begin
                byp[i] = '0;
            end
        end
    end

    // Later non-blocking assignments take effect, so the highest write port wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(ZERO_REG))) begin
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_en[i]) begin
                    rd_data[i*DW +: DW] <= byp[i];
                    rd_busy[i]          <= rd_pend[i];
                end
            end
        end
    end

endmodule
